// File: rtl/prf_mp_pkg.sv
// prf_mp_pkg: shared default sizes and tag/data types for the physical register file.
package prf_mp_pkg;
    localparam int DEF_NUM_PHY   = 64;
    localparam int DEF_PHY_W     = $clog2(DEF_NUM_PHY);
    localparam int DEF_XLEN      = 32;
    localparam int DEF_NUM_ARCH  = 32;
    localparam int DEF_NUM_RD    = 6;
    localparam int DEF_NUM_WR    = 3;
    localparam int DEF_NUM_ALLOC = 2;
    typedef logic [DEF_PHY_W-1:0] phy_tag_t;
    typedef logic [DEF_XLEN-1:0]  xlen_t;
endpackage

// File: rtl/prf_mp_if.sv
// prf_mp_if: rename/read/writeback/retire bundle of the register file; slave is the register file side.
interface prf_mp_if
    import prf_mp_pkg::*;
#(
    parameter int NUM_PHY   = DEF_NUM_PHY,
    parameter int PHY_W     = $clog2(NUM_PHY),
    parameter int XLEN      = DEF_XLEN,
    parameter int NUM_RD    = DEF_NUM_RD,
    parameter int NUM_WR    = DEF_NUM_WR,
    parameter int NUM_ALLOC = DEF_NUM_ALLOC
);
    logic                       flush;
    logic [NUM_ALLOC-1:0]       alloc_valid;
    logic [NUM_ALLOC*PHY_W-1:0] alloc_phy;
    logic [NUM_RD-1:0]          rd_valid;
    logic [NUM_RD*PHY_W-1:0]    rd_phy;
    logic [NUM_RD*XLEN-1:0]     rd_data;
    logic [NUM_WR-1:0]          wr_valid;
    logic [NUM_WR*PHY_W-1:0]    wr_phy;
    logic [NUM_WR*XLEN-1:0]     wr_data;
    logic                       retire_valid;
    logic [PHY_W-1:0]           retire_old_phy;
    logic [PHY_W-1:0]           retire_new_phy;
    logic [NUM_PHY-1:0]         ready_o;
    logic [NUM_PHY-1:0]         busy_o;
    logic                       wr_conflict_o;
    modport master (
        output flush, alloc_valid, alloc_phy, rd_valid, rd_phy, wr_valid, wr_phy, wr_data,
               retire_valid, retire_old_phy, retire_new_phy,
        input  rd_data, ready_o, busy_o, wr_conflict_o
    );
    modport slave (
        input  flush, alloc_valid, alloc_phy, rd_valid, rd_phy, wr_valid, wr_phy, wr_data,
               retire_valid, retire_old_phy, retire_new_phy,
        output rd_data, ready_o, busy_o, wr_conflict_o
    );
endinterface

// File: rtl/prf_scoreboard.sv
// prf_scoreboard: ready/busy vectors with retire < allocate < writeback priority and flush override.
// PRF_BYPASS_EN: ready_o also shows same-cycle writeback wakeups.
module prf_scoreboard
    import prf_mp_pkg::*;
#(
    parameter int NUM_PHY   = DEF_NUM_PHY,
    parameter int PHY_W     = $clog2(NUM_PHY),
    parameter int NUM_ARCH  = DEF_NUM_ARCH,
    parameter int NUM_WR    = DEF_NUM_WR,
    parameter int NUM_ALLOC = DEF_NUM_ALLOC
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [NUM_ALLOC-1:0]       alloc_valid,
    input  logic [NUM_ALLOC*PHY_W-1:0] alloc_phy,
    input  logic [NUM_WR-1:0]          wr_valid,
    input  logic [NUM_WR*PHY_W-1:0]    wr_phy,
    input  logic                       retire_valid,
    input  logic [PHY_W-1:0]           retire_old_phy,
    input  logic [PHY_W-1:0]           retire_new_phy,
    output logic [NUM_PHY-1:0]         ready_o,
    output logic [NUM_PHY-1:0]         busy_o
);
    logic [NUM_PHY-1:0] ready_q, busy_q, ready_d, busy_d, wake;

    always_comb begin
        wake = '0;
        for (int j = 0; j < NUM_WR; j++)
            if (wr_valid[j] && !flush) wake[wr_phy[j*PHY_W +: PHY_W]] = 1'b1;
        wake[0] = 1'b0;
    end

    always_comb begin
        ready_d = ready_q;
        busy_d  = busy_q;
        if (retire_valid) begin
            if (retire_old_phy != retire_new_phy && !busy_q[retire_old_phy]) ready_d[retire_old_phy] = 1'b0;
            busy_d[retire_new_phy] = 1'b0;
        end
        for (int i = 0; i < NUM_ALLOC; i++)
            if (alloc_valid[i]) begin
                busy_d[alloc_phy[i*PHY_W +: PHY_W]]  = 1'b1;
                ready_d[alloc_phy[i*PHY_W +: PHY_W]] = 1'b0;
            end
        ready_d = ready_d | wake;
        if (flush) begin
            ready_d = ready_q;
            busy_d  = '0;
        end
        ready_d[0] = 1'b1;
        busy_d[0]  = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ready_q <= {{(NUM_PHY-NUM_ARCH){1'b0}}, {NUM_ARCH{1'b1}}};
            busy_q  <= '0;
        end else begin
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end

`ifdef PRF_BYPASS_EN
    assign ready_o = ready_q | wake;
`else
    assign ready_o = ready_q;
`endif
    assign busy_o = busy_q;
endmodule

// File: rtl/prf_mp.sv
// prf_mp: multi-ported physical register file with scoreboard, hardwired tag 0 and sticky write-conflict flag.
// PRF_BYPASS_EN: same-cycle writeback data is forwarded to the read ports.
module prf_mp
    import prf_mp_pkg::*;
#(
    parameter int NUM_PHY   = DEF_NUM_PHY,
    parameter int PHY_W     = $clog2(NUM_PHY),
    parameter int XLEN      = DEF_XLEN,
    parameter int NUM_ARCH  = DEF_NUM_ARCH,
    parameter int NUM_RD    = DEF_NUM_RD,
    parameter int NUM_WR    = DEF_NUM_WR,
    parameter int NUM_ALLOC = DEF_NUM_ALLOC
) (
    input logic     clk,
    input logic     rst_n,
    prf_mp_if.slave bus
);
    logic [XLEN-1:0]        mem [NUM_PHY];
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic                   conflict, conflict_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int k = 0; k < NUM_PHY; k++) mem[k] <= '0;
        end else if (!bus.flush) begin
            for (int j = 0; j < NUM_WR; j++)
                if (bus.wr_valid[j] && bus.wr_phy[j*PHY_W +: PHY_W] != '0)
                    mem[bus.wr_phy[j*PHY_W +: PHY_W]] <= bus.wr_data[j*XLEN +: XLEN];
        end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++)
            if (bus.rd_valid[i]) begin
                rd_data[i*XLEN +: XLEN] = mem[bus.rd_phy[i*PHY_W +: PHY_W]];
`ifdef PRF_BYPASS_EN
                for (int j = 0; j < NUM_WR; j++)
                    if (bus.wr_valid[j] && !bus.flush && bus.wr_phy[j*PHY_W +: PHY_W] != '0 &&
                        bus.wr_phy[j*PHY_W +: PHY_W] == bus.rd_phy[i*PHY_W +: PHY_W])
                        rd_data[i*XLEN +: XLEN] = bus.wr_data[j*XLEN +: XLEN];
`endif
            end
    end

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < NUM_WR; i++)
            for (int j = i + 1; j < NUM_WR; j++)
                if (bus.wr_valid[i] && bus.wr_valid[j] && bus.wr_phy[i*PHY_W +: PHY_W] != '0 &&
                    bus.wr_phy[i*PHY_W +: PHY_W] == bus.wr_phy[j*PHY_W +: PHY_W])
                    conflict = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) conflict_q <= 1'b0;
        else if (conflict && !bus.flush) conflict_q <= 1'b1;

    prf_scoreboard #(
        .NUM_PHY(NUM_PHY), .PHY_W(PHY_W), .NUM_ARCH(NUM_ARCH), .NUM_WR(NUM_WR), .NUM_ALLOC(NUM_ALLOC)
    ) u_sb (
        .clk(clk), .rst_n(rst_n), .flush(bus.flush),
        .alloc_valid(bus.alloc_valid), .alloc_phy(bus.alloc_phy),
        .wr_valid(bus.wr_valid), .wr_phy(bus.wr_phy),
        .retire_valid(bus.retire_valid), .retire_old_phy(bus.retire_old_phy), .retire_new_phy(bus.retire_new_phy),
        .ready_o(bus.ready_o), .busy_o(bus.busy_o)
    );

    assign bus.rd_data       = rd_data;
    assign bus.wr_conflict_o = conflict_q;
endmodule

// File: tb/tb_prf_mp.sv
// tb_prf_mp: directed checks of prf_mp reset, allocate/write, tag 0, conflict, retire and flush.
module tb_prf_mp;
    import prf_mp_pkg::*;
    localparam int W = DEF_PHY_W;
    localparam int X = DEF_XLEN;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total  = 0;

    prf_mp_if bus ();
    prf_mp dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.alloc_valid  = '0;
        bus.wr_valid     = '0;
        bus.retire_valid = 1'b0;
        bus.flush        = 1'b0;
        #1;
    endtask

    task automatic rd(input int port, input phy_tag_t t, output logic [X-1:0] d);
        bus.rd_valid[port] = 1'b1;
        bus.rd_phy[port*W +: W] = t;
        #1;
        d = bus.rd_data[port*X +: X];
    endtask

    task automatic alloc(input int port, input phy_tag_t t);
        bus.alloc_valid[port] = 1'b1;
        bus.alloc_phy[port*W +: W] = t;
    endtask

    task automatic wr(input int port, input phy_tag_t t, input logic [X-1:0] d);
        bus.wr_valid[port] = 1'b1;
        bus.wr_phy[port*W +: W] = t;
        bus.wr_data[port*X +: X] = d;
    endtask

    task automatic retire(input phy_tag_t o, input phy_tag_t n);
        bus.retire_valid = 1'b1;
        bus.retire_old_phy = o;
        bus.retire_new_phy = n;
    endtask

    logic [X-1:0] d;

    initial begin
        bus.flush = 1'b0; bus.alloc_valid = '0; bus.alloc_phy = '0;
        bus.rd_valid = '0; bus.rd_phy = '0; bus.wr_valid = '0; bus.wr_phy = '0; bus.wr_data = '0;
        bus.retire_valid = 1'b0; bus.retire_old_phy = '0; bus.retire_new_phy = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset_ready", bus.ready_o, 64'h00000000_FFFFFFFF);
        chk("reset_busy", bus.busy_o, 64'h0);
        chk("reset_conflict", {63'h0, bus.wr_conflict_o}, 64'h0);
        rd(0, 7, d);  chk("reset_rd7", {32'h0, d}, 64'h0);
        rd(3, 40, d); chk("reset_rd40_p3", {32'h0, d}, 64'h0);

        alloc(0, 40); tick();
        chk("alloc_busy40", {63'h0, bus.busy_o[40]}, 64'h1);
        chk("alloc_ready40", {63'h0, bus.ready_o[40]}, 64'h0);

        wr(0, 40, 32'hDEADBEEF);
        rd(0, 40, d);
`ifdef PRF_BYPASS_EN
        chk("bypass_rd40", {32'h0, d}, 64'hDEADBEEF);
        chk("bypass_ready40", {63'h0, bus.ready_o[40]}, 64'h1);
`else
        chk("nobypass_rd40", {32'h0, d}, 64'h0);
        chk("nobypass_ready40", {63'h0, bus.ready_o[40]}, 64'h0);
`endif
        tick();
        rd(0, 40, d); chk("wr_rd40", {32'h0, d}, 64'hDEADBEEF);
        chk("wr_ready40", {63'h0, bus.ready_o[40]}, 64'h1);
        bus.rd_valid[0] = 1'b0; #1;
        chk("rd_disabled", {32'h0, bus.rd_data[31:0]}, 64'h0);

        wr(1, 0, 32'h1234); tick();
        rd(0, 0, d); chk("tag0_rd", {32'h0, d}, 64'h0);
        chk("tag0_ready_busy", {62'h0, bus.ready_o[0], bus.busy_o[0]}, 64'h2);
        chk("tag0_no_conflict", {63'h0, bus.wr_conflict_o}, 64'h0);

        wr(0, 33, 32'hAA); wr(2, 33, 32'hBB); tick();
        rd(0, 33, d); chk("conflict_rd33", {32'h0, d}, 64'hBB);
        chk("conflict_flag", {63'h0, bus.wr_conflict_o}, 64'h1);
        rd(5, 40, d); chk("port5_rd40", {32'h0, d}, 64'hDEADBEEF);
        tick();
        chk("conflict_sticky", {63'h0, bus.wr_conflict_o}, 64'h1);

        retire(5, 40); alloc(1, 5); tick();
        chk("ret_busy5", {63'h0, bus.busy_o[5]}, 64'h1);
        chk("ret_ready5", {63'h0, bus.ready_o[5]}, 64'h0);
        chk("ret_busy40", {63'h0, bus.busy_o[40]}, 64'h0);
        chk("ret_ready40", {63'h0, bus.ready_o[40]}, 64'h1);

        retire(6, 40); tick();
        chk("ret_ready6", {63'h0, bus.ready_o[6]}, 64'h0);

        wr(0, 5, 32'h55); tick();
        retire(5, 5); tick();
        chk("ret_same_ready5", {63'h0, bus.ready_o[5]}, 64'h1);
        chk("ret_same_busy5", {63'h0, bus.busy_o[5]}, 64'h0);

        alloc(0, 42); tick();
        wr(1, 42, 32'h42); tick();
        retire(42, 9); tick();
        chk("ret_busyold_ready42", {63'h0, bus.ready_o[42]}, 64'h1);

        alloc(0, 45); wr(2, 45, 32'h45); tick();
        chk("wr_beats_alloc", {62'h0, bus.ready_o[45], bus.busy_o[45]}, 64'h3);

        wr(0, 41, 32'h4141); tick();
        bus.flush = 1'b1; alloc(0, 50); wr(1, 41, 32'h9999); tick();
        chk("flush_busy", bus.busy_o, 64'h0);
        chk("flush_ready50", {63'h0, bus.ready_o[50]}, 64'h0);
        chk("flush_ready41", {63'h0, bus.ready_o[41]}, 64'h1);
        rd(0, 41, d); chk("flush_rd41", {32'h0, d}, 64'h4141);
        chk("flush_keep_conflict", {63'h0, bus.wr_conflict_o}, 64'h1);

        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_conflict", {63'h0, bus.wr_conflict_o}, 64'h0);
        chk("async_rst_ready", bus.ready_o, 64'h00000000_FFFFFFFF);
        rd(0, 40, d); chk("async_rst_rd40", {32'h0, d}, 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        alloc(0, 60); tick();
        chk("post_rst_alloc", {62'h0, bus.busy_o[60], bus.ready_o[60]}, 64'h2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/prf_mp.md
# prf_mp

Multi-ported physical register file with an integrated ready/busy scoreboard for the out-of-order core. It generalises the fixed three-consumer register file to a parametrised number of read ports, writeback ports and rename allocation ports. It adds a hardwired zero register, optional write-to-read bypass, and a sticky writeback-conflict detector. It sits between rename (allocate), the issue/execute read stage, writeback, and retire.

## Interface
- NUM_PHY, 64, number of physical registers.
- PHY_W, $clog2(NUM_PHY), physical tag width.
- XLEN, 32, data width.
- NUM_ARCH, 32, registers 0..NUM_ARCH-1 are ready at reset.
- NUM_RD, 6, read ports (2 per execution unit).
- NUM_WR, 3, writeback ports.
- NUM_ALLOC, 2, rename allocation ports.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  pipeline flush.
- alloc_valid  in  NUM_ALLOC  allocate port i.
- alloc_phy  in  NUM_ALLOC*PHY_W  tag being allocated.
- rd_valid  in  NUM_RD  read port enable.
- rd_phy  in  NUM_RD*PHY_W  read tag.
- rd_data  out  NUM_RD*XLEN  read data.
- wr_valid  in  NUM_WR  writeback enable.
- wr_phy  in  NUM_WR*PHY_W  writeback tag.
- wr_data  in  NUM_WR*XLEN  writeback data.
- retire_valid  in  1  retire event.
- retire_old_phy  in  PHY_W  previous mapping being freed.
- retire_new_phy  in  PHY_W  mapping being committed.
- ready_o  out  NUM_PHY  1 = data valid.
- busy_o  out  NUM_PHY  1 = allocated, not yet retired.
- wr_conflict_o  out  1  sticky: two write ports hit one tag in one cycle.

## Operation
- Tag 0 is hardwired: reads return 0, writes are dropped, ready_o[0]=1 and busy_o[0]=0 always.
- Reads are combinational. rd_data port i = array[rd_phy i] when rd_valid[i], else 0.
- Allocate port i: busy[tag]<=1, ready[tag]<=0.
- Write port j (tag≠0): array[tag]<=data, ready[tag]<=1.
- Retire: ready[old]<=0 unless busy[old] is set (re-allocated), busy[new]<=0. If old==new, only busy is cleared.
- Update order within one cycle: retire, then allocate, then writeback. The later update wins on the same tag, so a writeback beats an allocate for ready, and an allocate beats a retire.
- flush (non-reset) has highest priority:
  - busy<=0 for all tags.
  - ready and array unchanged.
  - alloc, write and retire in that cycle are ignored.
- Conflict: two or more wr_valid with equal non-zero tags in one cycle sets wr_conflict_o <=1 on the next edge. The flag holds until reset. The highest-index port's data is written.

## Timing
- Reset values (asserted asynchronously):
  - array all 0.
  - ready_o = ones on 0..NUM_ARCH-1, zeros elsewhere.
  - busy_o = 0.
  - wr_conflict_o = 0.
- A write is visible on rd_data the cycle after wr_valid (without bypass). ready_o and busy_o update one cycle after the event.
- Reset deasserted mid-operation: the first edge after release performs normal updates; no in-flight state is kept.

## Configuration
- PRF_BYPASS_EN defined:
  - rd_data forwards same-cycle wr_data when a write tag equals the read tag (highest matching write port wins; tag 0 never forwarded).
  - ready_o is the registered ready OR the current-cycle write wakeup.
  - Read-after-write latency is 0.
- Not defined: no forwarding, ready_o is purely registered, latency is 1 cycle.

## Structure
- Shared package (parameter_pkg/typedef_pkg) holds:
  - phy_tag_t, xlen_t.
  - Default NUM_PHY, NUM_RD, NUM_WR, NUM_ALLOC constants.
- One sub-module, prf_scoreboard: holds the ready/busy vectors, update priority and flush. The data array, read mux, bypass and conflict detector stay in prf_mp.

## Test plan
- Reset: release rst_n → ready_o=0x00000000_FFFFFFFF, busy_o=0, all reads 0, wr_conflict_o=0.
- Allocate tag 40, then write 0xDEADBEEF to 40 on the next cycle:
  - after the allocate: busy[40]=1, ready[40]=0.
  - next cycle: rd_data(40)=0xDEADBEEF, ready[40]=1.
  - with PRF_BYPASS_EN: the value and ready appear in the write cycle itself.
- Write 0x1234 to tag 0 → rd_data(0)=0, ready_o[0]=1.
- Conflict: ports 0 and 2 both write tag 33 (0xAA, 0xBB) → tag 33 reads 0xBB, wr_conflict_o=1 and stays 1 until rst_n.
- Retire with old=5 (busy=0), new=40 → ready[5]=0, busy[40]=0. Same cycle allocate 5 → busy[5]=1, ready[5]=0.
- Flush with alloc 50 and write 41 in the same cycle → busy_o=0, ready[50] and ready[41] unchanged, tag 41 data unchanged.
